// File: rtl/test_monitor_pkg.sv
// Shared encodings for the end-of-test monitor: verdicts, FSM states and
// the default signature codes that ISA tests write to x31.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] VERDICT_NONE  = 2'b00;
  localparam logic [1:0] VERDICT_PASS  = 2'b01;
  localparam logic [1:0] VERDICT_FAIL  = 2'b10;
  localparam logic [1:0] VERDICT_ERROR = 2'b11;

  localparam logic [31:0] DEFAULT_PASS_CODE = 32'h55;
  localparam logic [31:0] DEFAULT_FAIL_CODE = 32'haa;

endpackage

// File: rtl/test_monitor_hart.sv
// Per-hart channel: sticky halt flag, first-halt cycle capture and
// signature classification into a latched verdict.
module test_monitor_hart
  import test_monitor_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     CNT_W     = 32,
  parameter logic [XLEN-1:0] PASS_CODE = XLEN'(DEFAULT_PASS_CODE),
  parameter logic [XLEN-1:0] FAIL_CODE = XLEN'(DEFAULT_FAIL_CODE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             track,
  input  logic             sample,
  input  logic             halt,
  input  logic [XLEN-1:0]  sig,
  input  logic [CNT_W-1:0] cycle,
  output logic             halted_c,
  output logic             pass_c,
  output logic [CNT_W-1:0] halt_cycle,
  output logic [1:0]       verdict
);

  logic       seen;
  logic [1:0] verdict_c;

  // A halt arriving on the sampling clock itself still counts as halted.
  always_comb begin
    halted_c  = seen | halt;
    verdict_c = VERDICT_ERROR;
    if (halted_c) begin
      if (sig == PASS_CODE)      verdict_c = VERDICT_PASS;
      else if (sig == FAIL_CODE) verdict_c = VERDICT_FAIL;
    end
    pass_c = (verdict_c == VERDICT_PASS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen       <= 1'b0;
      halt_cycle <= '0;
      verdict    <= VERDICT_NONE;
    end else begin
      if (track && halt && !seen) begin
        seen       <= 1'b1;
        halt_cycle <= cycle;
      end
      if (sample) verdict <= verdict_c;
    end
  end

endmodule

// File: rtl/test_monitor.sv
// End-of-test monitor: shared cycle/settle counters and RUN/SETTLE/DONE
// sequencing around NUM_HARTS per-hart channels.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int unsigned     NUM_HARTS = 1,
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     CNT_W     = 32,
  parameter int unsigned     TIMEOUT   = 10000,
  parameter int unsigned     SETTLE    = 1,
  parameter logic [XLEN-1:0] PASS_CODE = XLEN'(DEFAULT_PASS_CODE),
  parameter logic [XLEN-1:0] FAIL_CODE = XLEN'(DEFAULT_FAIL_CODE)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_HARTS-1:0]       halt,
  input  logic [NUM_HARTS*XLEN-1:0]  sig,
  output logic [CNT_W-1:0]           cycle,
  output logic [NUM_HARTS*CNT_W-1:0] halt_cycle,
  output logic [NUM_HARTS*2-1:0]     verdict,
  output logic                       done,
  output logic                       timeout,
  output logic                       pass
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t               state, state_next;
  logic [SET_W-1:0]     settle_cnt;
  logic                 timed_out;
  logic [NUM_HARTS-1:0] halted_c;
  logic [NUM_HARTS-1:0] pass_c;
  logic                 track_c;
  logic                 all_halted_c;
  logic                 hit_timeout_c;
  logic                 end_c;
  logic                 sample_c;

  for (genvar i = 0; i < NUM_HARTS; i++) begin : g_hart
    test_monitor_hart #(
      .XLEN      (XLEN),
      .CNT_W     (CNT_W),
      .PASS_CODE (PASS_CODE),
      .FAIL_CODE (FAIL_CODE)
    ) u_hart (
      .clk        (clk),
      .rst        (rst),
      .track      (track_c),
      .sample     (sample_c),
      .halt       (halt[i]),
      .sig        (sig[i*XLEN +: XLEN]),
      .cycle      (cycle),
      .halted_c   (halted_c[i]),
      .pass_c     (pass_c[i]),
      .halt_cycle (halt_cycle[i*CNT_W +: CNT_W]),
      .verdict    (verdict[i*2 +: 2])
    );
  end

  // Next-state and per-clock strobes.
  always_comb begin
    state_next    = state;
    end_c         = 1'b0;
    sample_c      = 1'b0;
    track_c       = (state != ST_DONE);
    all_halted_c  = &halted_c;
    hit_timeout_c = (cycle == CNT_W'(TIMEOUT - 1));
    case (state)
      ST_RUN: begin
        if (all_halted_c || hit_timeout_c) begin
          end_c      = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SET_W'(SETTLE - 1)) begin
          sample_c   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Counters and result latch; halt beats timeout when both land together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle      <= '0;
      settle_cnt <= '0;
      timed_out  <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      pass       <= 1'b0;
    end else begin
      if (state != ST_DONE) cycle <= cycle + 1'b1;
      if (end_c) begin
        settle_cnt <= '0;
        timed_out  <= !all_halted_c;
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (sample_c) begin
        done    <= 1'b1;
        timeout <= timed_out;
        pass    <= !timed_out && (&pass_c);
      end
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// Scoreboard bench for test_monitor: expected results come from a
// closed-form model of end cycle, sample cycle and signature decode.
module tb_test_monitor;

  localparam int unsigned NH      = 2;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned TIMEOUT = 150;
  localparam int unsigned SETTLE  = 3;
  localparam int          NEVER   = 1000000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NH-1:0]         halt;
  logic [NH*XLEN-1:0]    sig;
  logic [CNT_W-1:0]      cycle;
  logic [NH*CNT_W-1:0]   halt_cycle;
  logic [NH*2-1:0]       verdict;
  logic                  done, timeout, pass;

  test_monitor #(
    .NUM_HARTS (NH),
    .XLEN      (XLEN),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TIMEOUT),
    .SETTLE    (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .halt       (halt),
    .sig        (sig),
    .cycle      (cycle),
    .halt_cycle (halt_cycle),
    .verdict    (verdict),
    .done       (done),
    .timeout    (timeout),
    .pass       (pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0]    cyc;
    logic [NH*CNT_W-1:0] hc;
    logic [NH*2-1:0]     v;
    logic                to;
    logic                ps;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;   // clock edges since reset release
  bit   seen     = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, k);
    end
  endtask

  // Reference: end at the last first-halt or at TIMEOUT-1, sample SETTLE
  // edges later, cycle freezes one past the sampling edge.
  function automatic exp_t model(input int h[NH], input logic [31:0] e[NH],
                                 input logic [31:0] f[NH], input int sw[NH]);
    exp_t r;
    int allh, ev, s;
    bit to, ps;
    logic [31:0] sv;
    logic [1:0] vv;
    allh = 0;
    foreach (h[i]) if (h[i] > allh) allh = h[i];
    if (allh <= int'(TIMEOUT) - 1) begin ev = allh; to = 0; end
    else begin ev = int'(TIMEOUT) - 1; to = 1; end
    s  = ev + int'(SETTLE);
    ps = !to;
    r.hc = '0;
    r.v  = '0;
    for (int i = 0; i < NH; i++) begin
      sv = (s >= sw[i]) ? f[i] : e[i];
      if (h[i] > s)          vv = 2'b11;
      else if (sv == 32'h55) vv = 2'b01;
      else if (sv == 32'haa) vv = 2'b10;
      else                   vv = 2'b11;
      if (h[i] <= s) r.hc[i*CNT_W +: CNT_W] = CNT_W'(h[i]);
      r.v[i*2 +: 2] = vv;
      if (vv != 2'b01) ps = 0;
    end
    r.cyc = CNT_W'(s + 1);
    r.to  = to;
    r.ps  = ps;
    return r;
  endfunction

  // Monitor: compares the first done of each run against the scoreboard.
  always @(negedge clk) begin
    if (!rst && done && !seen) begin
      exp_t e;
      seen = 1;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sbq.pop_front();
        chk("done_edge",  64'(k),          64'(e.cyc));
        chk("cycle",      64'(cycle),      64'(e.cyc));
        chk("halt_cycle", 64'(halt_cycle), 64'(e.hc));
        chk("verdict",    64'(verdict),    64'(e.v));
        chk("timeout",    64'(timeout),    64'(e.to));
        chk("pass",       64'(pass),       64'(e.ps));
      end
    end
  end

  task automatic do_reset();
    rst  = 1'b1;
    #1;
    chk("rst_cycle",      64'(cycle),      64'(0));
    chk("rst_halt_cycle", 64'(halt_cycle), 64'(0));
    chk("rst_verdict",    64'(verdict),    64'(0));
    chk("rst_done",       64'(done),       64'(0));
    chk("rst_timeout",    64'(timeout),    64'(0));
    chk("rst_pass",       64'(pass),       64'(0));
    halt = '0;
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    k    = 0;
    seen = 0;
  endtask

  task automatic run(input int h0, input int h1, input int d0, input int d1,
                     input logic [31:0] e0, input logic [31:0] f0,
                     input logic [31:0] e1, input logic [31:0] f1,
                     input int sw0, input int sw1, input int abort_k);
    int h[NH], d[NH], sw[NH];
    logic [31:0] e[NH], f[NH];
    exp_t x;
    int budget;
    bit aborted;
    h = '{h0, h1}; d = '{d0, d1}; sw = '{sw0, sw1};
    e = '{e0, e1}; f = '{f0, f1};
    x = model(h, e, f, sw);
    sbq.push_back(x);
    budget  = int'(x.cyc) + 4;
    aborted = 0;
    for (int step = 0; step < budget; step++) begin
      if (k == abort_k) begin aborted = 1; break; end
      for (int i = 0; i < NH; i++) begin
        halt[i] = (k >= h[i]) && (k < d[i]);
        sig[i*XLEN +: XLEN] = (k >= sw[i]) ? f[i] : e[i];
      end
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    if (aborted) begin
      sbq.delete();
    end else begin
      chk("done_seen", 64'(sbq.size()), 64'(0));
      sbq.delete();
      chk("done_held",   64'(done),  64'(1));
      chk("cycle_held",  64'(cycle), 64'(x.cyc));
    end
    do_reset();
  endtask

  initial begin
    int h0, h1;
    logic [31:0] c[4];
    rst  = 1'b1;
    halt = '0;
    sig  = '0;
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // Staggered halts, hart0 halt drops later.
    run(10, 40, 20, NEVER, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, -1);
    // Fail and error signatures.
    run(5, 5, NEVER, NEVER, 32'haa, 32'haa, 32'h12, 32'h12, 0, 0, -1);
    // No halt at all: timeout.
    run(NEVER, NEVER, NEVER, NEVER, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, -1);
    // Signature flips during the settle window.
    run(20, 20, NEVER, NEVER, 32'haa, 32'h55, 32'haa, 32'h55, 0, 22, -1);
    // Last halt on the timeout clock: halt wins.
    run(30, 149, NEVER, NEVER, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, -1);
    // Timeout with a late halt inside and after the settle window.
    run(30, 151, NEVER, NEVER, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, -1);
    run(30, 153, NEVER, NEVER, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, -1);
    // Reset mid-SETTLE and mid-DONE, then a clean rerun.
    run(10, 40, 20, NEVER, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, 42);
    run(10, 40, 20, NEVER, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, 46);
    run(10, 40, 20, NEVER, 32'h55, 32'h55, 32'h55, 32'h55, 0, 0, -1);

    for (int r = 0; r < 30; r++) begin
      for (int j = 0; j < 4; j++) begin
        case ($urandom % 4)
          0, 1:    c[j] = 32'h55;
          2:       c[j] = 32'haa;
          default: c[j] = $urandom;
        endcase
      end
      h0 = ($urandom % 5 == 0) ? NEVER : int'($urandom_range(0, 170));
      h1 = ($urandom % 5 == 0) ? NEVER : int'($urandom_range(0, 170));
      run(h0, h1, h0 + int'($urandom_range(1, 60)), h1 + int'($urandom_range(1, 60)),
          c[0], c[1], c[2], c[3],
          int'($urandom_range(0, 200)), int'($urandom_range(0, 200)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
